// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the multi-cycle RV32I sequencer:
// state enum, opcode constants, mux/ALU encodings and opcode helpers.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_LUI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LINK, S_ERROR
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_WDATA = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // True for every opcode the sequencer knows how to execute.
  function automatic logic is_known_op(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  // Immediate format implied by the opcode; unknown opcodes fall back to I.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:          return IMM_S;
      OP_BRANCH:         return IMM_B;
      OP_JAL:            return IMM_J;
      OP_LUI, OP_AUIPC:  return IMM_U;
      default:           return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/main_fsm_if.sv
// Control bundle between the main sequencer (master) and the datapath (slave).
// The illegal flag exists only when MAIN_FSM_ILLEGAL_TRAP_EN is defined.
interface main_fsm_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       lt;
  logic       ltu;
  logic       mem_ready;
  logic       PCWrite;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       AdrSrc;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [2:0] ImmSrc;
  logic       instr_done;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  modport master (
    input  op, funct3, zero, lt, ltu, mem_ready,
    output PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    , output illegal
`endif
  );

  modport slave (
    output op, funct3, zero, lt, ltu, mem_ready,
    input  PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    , input illegal
`endif
  );

endinterface

// File: rtl/branch_cond.sv
// Branch outcome: maps funct3 and the rs1-rs2 ALU flags to "taken".
module branch_cond
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       lt_i,
  input  logic       ltu_i,
  output logic       taken_o
);

  // Select the flag (or its inverse) that decides this branch flavour.
  always_comb begin
    taken_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = zero_i;
      F3_BNE:  taken_o = !zero_i;
      F3_BLT:  taken_o = lt_i;
      F3_BGE:  taken_o = !lt_i;
      F3_BLTU: taken_o = ltu_i;
      F3_BGEU: taken_o = !ltu_i;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// Multi-cycle RV32I control sequencer (Moore FSM with mem_ready stalls).
// Optional feature macro: MAIN_FSM_ILLEGAL_TRAP_EN -- unknown opcodes trap
// into S_ERROR (with the illegal flag) instead of retiring as a 2-cycle NOP.
module main_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned RESET_STALL = 1
) (
  input  logic       clk,
  input  logic       reset,
  main_fsm_if.master bus
);

  localparam logic [3:0] STALL_LAST = 4'(RESET_STALL - 1);

`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
  localparam state_t BAD_OP_NEXT = S_ERROR;
  localparam state_t ERROR_NEXT  = S_ERROR;
`else
  localparam state_t BAD_OP_NEXT = S_FETCH;
  localparam state_t ERROR_NEXT  = S_FETCH;
`endif

  state_t     state_q, state_d;
  logic [3:0] stall_cnt_q, stall_cnt_d;

  logic       taken;
  logic       pc_update, branch, ir_write, mem_write, reg_write, adr_src, instr_done;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src;

  branch_cond u_branch_cond (
    .funct3_i (bus.funct3),
    .zero_i   (bus.zero),
    .lt_i     (bus.lt),
    .ltu_i    (bus.ltu),
    .taken_o  (taken)
  );

  // State register and post-reset idle counter; reset pulls back to S_RESET at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RESET;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state logic: walk fetch/decode/execute/memory/write-back, holding on mem_ready.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      S_RESET: begin
        if (stall_cnt_q == STALL_LAST) begin
          state_d     = S_FETCH;
          stall_cnt_d = '0;
        end else begin
          stall_cnt_d = stall_cnt_q + 4'd1;
        end
      end
      S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALUWB;
          default:           state_d = BAD_OP_NEXT;
        endcase
      end
      S_MEMADR:   state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_EXECR, S_EXECI, S_LUI:              state_d = S_ALUWB;
      S_JAL, S_JALR:                        state_d = S_LINK;
      S_MEMWB, S_ALUWB, S_BRANCH, S_LINK:   state_d = S_FETCH;
      S_ERROR:    state_d = ERROR_NEXT;
      default:    state_d = S_RESET;
    endcase
  end

  // Output decode: strobes and mux selects per state, everything else held at 0.
  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    instr_done = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_WDATA;
    alu_op     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = bus.mem_ready;
        pc_update  = bus.mem_ready;
      end
      S_DECODE: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_IMM;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
        instr_done = 1'b0;
`else
        instr_done = !is_known_op(bus.op);
`endif
      end
      S_MEMADR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = bus.mem_ready;
      end
      S_EXECR: begin
        alu_src_a = SRCA_A;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_A;
        alu_op     = ALUOP_SUB;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: pc_update = 1'b1;
      S_JALR: begin
        alu_src_a  = SRCA_A;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURESULT;
        pc_update  = 1'b1;
      end
      S_LINK: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Immediate format follows the opcode except while idle in reset or trapped.
  assign imm_src = (state_q == S_RESET || state_q == S_ERROR) ? IMM_I : imm_src_of(bus.op);

  assign bus.PCWrite    = pc_update | (branch & taken);
  assign bus.IRWrite    = ir_write;
  assign bus.MemWrite   = mem_write;
  assign bus.RegWrite   = reg_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUOp      = alu_op;
  assign bus.ImmSrc     = imm_src;
  assign bus.instr_done = instr_done;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
  assign bus.illegal    = (state_q == S_ERROR);
`endif

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: directed scenarios with full output
// vectors, plus randomized back-to-back instructions against a cycle/strobe
// count model. Honours MAIN_FSM_ILLEGAL_TRAP_EN when compiled with it.
module tb_main_fsm;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  logic clk;
  logic reset;
  int   checks;
  int   passes;

  main_fsm_if bus();

  main_fsm #(.RESET_STALL(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] obs;
  assign obs = {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.AdrSrc,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc,
                bus.instr_done};

  // Expected output vector built field by field.
  function automatic logic [16:0] ev(input logic pcw, input logic irw, input logic mw,
                                     input logic rw, input logic adr, input logic [1:0] res,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] aop, input logic [2:0] imm,
                                     input logic done);
    return {pcw, irw, mw, rw, adr, res, a, b, aop, imm, done};
  endfunction

  // Fetch cycle with memory ready.
  function automatic logic [16:0] fetchVec(input logic [2:0] imm);
    return ev(1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, imm, 0);
  endfunction

  // Decode cycle (OldPC + imm), done only for an untrapped unknown opcode.
  function automatic logic [16:0] decodeVec(input logic [2:0] imm, input logic done);
    return ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, imm, done);
  endfunction

  function automatic logic isKnown(input logic [6:0] o);
    return (o == OP_LW || o == OP_SW || o == OP_R || o == OP_I || o == OP_LUI ||
            o == OP_AUIPC || o == OP_BR || o == OP_JAL || o == OP_JALR);
  endfunction

  function automatic logic takenModel(input logic [2:0] f3, input logic z,
                                      input logic l, input logic lu);
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return l;
      3'd5:    return !l;
      3'd6:    return lu;
      3'd7:    return !lu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset and leave the bench at the start of the first fetch cycle.
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bus.op = OP_R; bus.funct3 = 3'd0; bus.mem_ready = 1'b1;
    bus.zero = 1'b0; bus.lt = 1'b0; bus.ltu = 1'b0;
    reset = 1'b0;
    repeat (2) tick();
    #1;
    checks++;
    if (obs !== 17'd0) $display("[TB] FAIL reset_hold: got %h, expected %h", obs, 17'd0);
    else passes++;
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== 17'd0) $display("[TB] FAIL reset_stall_cycle: got %h, expected %h", obs, 17'd0);
    else passes++;
    tick();
    #1;
    checks++;
    if (obs !== fetchVec(3'b000)) $display("[TB] FAIL first_fetch: got %h, expected %h", obs, fetchVec(3'b000));
    else passes++;
  endtask

  task automatic test_lw();
    logic [16:0] e [5];
    do_reset();
    bus.op = OP_LW; bus.funct3 = 3'b010; bus.mem_ready = 1'b1;
    e[0] = fetchVec(3'b000);
    e[1] = decodeVec(3'b000, 0);
    e[2] = ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0);
    e[3] = ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    e[4] = ev(0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (obs !== e[c]) $display("[TB] FAIL lw_cycle%0d: got %h, expected %h", c + 1, obs, e[c]);
      else passes++;
      tick();
    end
    #1;
    checks++;
    if (obs !== fetchVec(3'b000)) $display("[TB] FAIL lw_next_fetch: got %h, expected %h", obs, fetchVec(3'b000));
    else passes++;
  endtask

  task automatic test_sw_stall();
    logic [16:0] e [7];
    logic        ready [7];
    do_reset();
    bus.op = OP_SW; bus.funct3 = 3'b010;
    ready = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    e[0] = fetchVec(3'b001);
    e[1] = decodeVec(3'b001, 0);
    e[2] = ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b001, 0);
    for (int c = 3; c < 6; c++) e[c] = ev(0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 0);
    e[6] = ev(0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 1);
    for (int c = 0; c < 7; c++) begin
      bus.mem_ready = ready[c];
      #1;
      checks++;
      if (obs !== e[c]) $display("[TB] FAIL sw_cycle%0d: got %h, expected %h", c + 1, obs, e[c]);
      else passes++;
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== fetchVec(3'b001)) $display("[TB] FAIL sw_next_fetch: got %h, expected %h", obs, fetchVec(3'b001));
    else passes++;
  endtask

  task automatic test_branch();
    logic [16:0] e [4];
    for (int z = 0; z < 2; z++) begin
      do_reset();
      bus.op = OP_BR; bus.funct3 = 3'b001; bus.mem_ready = 1'b1;
      bus.zero = 1'(z); bus.lt = 1'($urandom); bus.ltu = 1'($urandom);
      e[0] = fetchVec(3'b010);
      e[1] = decodeVec(3'b010, 0);
      e[2] = ev(!1'(z), 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010, 1);
      e[3] = fetchVec(3'b010);
      for (int c = 0; c < 4; c++) begin
        #1;
        checks++;
        if (obs !== e[c]) $display("[TB] FAIL bne_zero%0d_cycle%0d: got %h, expected %h", z, c + 1, obs, e[c]);
        else passes++;
        tick();
      end
    end
  endtask

  task automatic test_jalr();
    logic [16:0] e [5];
    do_reset();
    bus.op = OP_JALR; bus.funct3 = 3'b000; bus.mem_ready = 1'b1;
    e[0] = fetchVec(3'b000);
    e[1] = decodeVec(3'b000, 0);
    e[2] = ev(1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, 2'b00, 3'b000, 0);
    e[3] = ev(0, 0, 0, 1, 0, 2'b10, 2'b01, 2'b10, 2'b00, 3'b000, 1);
    e[4] = fetchVec(3'b000);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (obs !== e[c]) $display("[TB] FAIL jalr_cycle%0d: got %h, expected %h", c + 1, obs, e[c]);
      else passes++;
      tick();
    end
  endtask

  task automatic test_illegal();
    do_reset();
    bus.op = 7'b1111111; bus.funct3 = 3'b000; bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== fetchVec(3'b000)) $display("[TB] FAIL illegal_fetch: got %h, expected %h", obs, fetchVec(3'b000));
    else passes++;
    tick();
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    #1;
    checks++;
    if (obs !== decodeVec(3'b000, 0)) $display("[TB] FAIL illegal_decode: got %h, expected %h", obs, decodeVec(3'b000, 0));
    else passes++;
    tick();
    for (int c = 0; c < 6; c++) begin
      bus.mem_ready = 1'($urandom);
      #1;
      checks++;
      if (obs !== 17'd0 || bus.illegal !== 1'b1)
        $display("[TB] FAIL illegal_trap%0d: got %h/%b, expected %h/1", c, obs, bus.illegal, 17'd0);
      else passes++;
      tick();
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.illegal !== 1'b0) $display("[TB] FAIL illegal_cleared: got %b, expected 0", bus.illegal);
    else passes++;
    reset = 1'b1;
`else
    #1;
    checks++;
    if (obs !== decodeVec(3'b000, 1)) $display("[TB] FAIL illegal_nop_decode: got %h, expected %h", obs, decodeVec(3'b000, 1));
    else passes++;
    tick();
    #1;
    checks++;
    if (obs !== fetchVec(3'b000)) $display("[TB] FAIL illegal_nop_refetch: got %h, expected %h", obs, fetchVec(3'b000));
    else passes++;
`endif
  endtask

  task automatic test_reset_midwrite();
    do_reset();
    bus.op = OP_SW; bus.funct3 = 3'b010; bus.mem_ready = 1'b1;
    repeat (3) tick();
    bus.mem_ready = 1'b0;
    #1;
    checks++;
    if (bus.MemWrite !== 1'b1) $display("[TB] FAIL midwrite_pre: got %b, expected 1", bus.MemWrite);
    else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== 17'd0) $display("[TB] FAIL midwrite_reset: got %h, expected %h", obs, 17'd0);
    else passes++;
  endtask

  // Random back-to-back instructions vs. a count model (cycles, strobes, ImmSrc).
  task automatic test_back_to_back();
    logic [6:0] ops  [9];
    logic [2:0] imms [9];
    int         base [9];
    ops  = '{OP_LW, OP_SW, OP_R, OP_I, OP_LUI, OP_AUIPC, OP_BR, OP_JAL, OP_JALR};
    imms = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b100, 3'b100, 3'b010, 3'b011, 3'b000};
    base = '{5, 4, 4, 4, 4, 3, 3, 4, 4};
    do_reset();
    for (int n = 0; n < 40; n++) begin
      int k, sf, sm, baseCyc, expCyc, expPcw, expReg, expMem, doneCyc, pcw, irw, mw, rw, immBad;
      logic [6:0] op;
      logic [6:0] cand;
      logic [2:0] f3, expImm;
      logic z, l, lu, tk, mr, isMem;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      k = $urandom_range(0, 8);
`else
      k = $urandom_range(0, 9);
`endif
      if (k < 9) begin
        op = ops[k]; expImm = imms[k]; baseCyc = base[k];
      end else begin
        op = 7'b1111111;
        for (int t = 0; t < 8; t++) begin
          cand = 7'($urandom);
          if (!isKnown(cand)) begin op = cand; break; end
        end
        expImm = 3'b000; baseCyc = 2;
      end
      isMem = (k < 2);
      sf = $urandom_range(0, 3);
      sm = isMem ? $urandom_range(0, 3) : 0;
      f3 = 3'($urandom); z = 1'($urandom); l = 1'($urandom); lu = 1'($urandom);
      tk = takenModel(f3, z, l, lu);
      expCyc = baseCyc + sf + sm;
      expPcw = 1 + ((k == 7 || k == 8) ? 1 : 0) + ((k == 6 && tk) ? 1 : 0);
      expReg = (k == 1 || k == 6 || k == 9) ? 0 : 1;
      expMem = (k == 1) ? 1 + sm : 0;
      bus.op = op; bus.funct3 = f3; bus.zero = z; bus.lt = l; bus.ltu = lu;
      doneCyc = 0; pcw = 0; irw = 0; mw = 0; rw = 0; immBad = 0;
      for (int c = 1; c <= 40; c++) begin
        if (c <= sf) mr = 1'b0;
        else if (c == sf + 1) mr = 1'b1;
        else if (isMem && c >= sf + 4 && c <= sf + 3 + sm) mr = 1'b0;
        else if (isMem && c == sf + 4 + sm) mr = 1'b1;
        else mr = 1'($urandom);
        bus.mem_ready = mr;
        #1;
        pcw += int'(bus.PCWrite === 1'b1);
        irw += int'(bus.IRWrite === 1'b1);
        mw  += int'(bus.MemWrite === 1'b1);
        rw  += int'(bus.RegWrite === 1'b1);
        if (bus.ImmSrc !== expImm) immBad++;
        if (bus.instr_done === 1'b1) doneCyc = c;
        tick();
        if (doneCyc != 0) break;
      end
      checks++;
      if (doneCyc != expCyc) $display("[TB] FAIL rnd%0d_cycles op=%b: got %0d, expected %0d", n, op, doneCyc, expCyc);
      else passes++;
      checks++;
      if (pcw != expPcw) $display("[TB] FAIL rnd%0d_pcwrite op=%b f3=%b: got %0d, expected %0d", n, op, f3, pcw, expPcw);
      else passes++;
      checks++;
      if (irw != 1) $display("[TB] FAIL rnd%0d_irwrite op=%b: got %0d, expected 1", n, op, irw);
      else passes++;
      checks++;
      if (rw != expReg) $display("[TB] FAIL rnd%0d_regwrite op=%b: got %0d, expected %0d", n, op, rw, expReg);
      else passes++;
      checks++;
      if (mw != expMem) $display("[TB] FAIL rnd%0d_memwrite op=%b: got %0d, expected %0d", n, op, mw, expMem);
      else passes++;
      checks++;
      if (immBad != 0) $display("[TB] FAIL rnd%0d_immsrc op=%b: got %0d bad cycles, expected 0", n, op, immBad);
      else passes++;
      if (doneCyc == 0) do_reset();
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    reset  = 1'b0;
    bus.op = 7'd0; bus.funct3 = 3'd0; bus.mem_ready = 1'b1;
    bus.zero = 1'b0; bus.lt = 1'b0; bus.ltu = 1'b0;
    test_reset();
    test_lw();
    test_sw_stall();
    test_branch();
    test_jalr();
    test_illegal();
    test_reset_midwrite();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
# main_fsm

Multi-cycle control sequencer for the RV32I core. It sits directly upstream of the ALU decoder and drives its `ALUOp` input, along with every datapath strobe and mux select, from a Moore state machine. The machine walks each instruction through fetch, decode, execute, memory and write-back, and stalls on a memory ready handshake.

## Interface
- `RESET_STALL`, default 1: number of idle cycles spent in `S_RESET` after reset deasserts, before the first fetch. Legal range 1–15.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `op` input 7: `instr[6:0]` from the instruction register.
- `funct3` input 3: `instr[14:12]`.
- `zero`, `lt`, `ltu` input 1 each: ALU flags for `rs1-rs2`.
- `mem_ready` input 1: the memory has completed this cycle's access.
- `PCWrite`, `IRWrite`, `MemWrite`, `RegWrite` output 1 each: datapath write strobes.
- `AdrSrc` output 1: memory address select. 0 = PC, 1 = Result.
- `ResultSrc` output 2: result select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` output 2: ALU operand A select. 00 = PC, 01 = OldPC, 10 = A, 11 = zero.
- `ALUSrcB` output 2: ALU operand B select. 00 = WriteData, 01 = ImmExt, 10 = 4.
- `ALUOp` output 2: to the ALU decoder. 00 = add, 01 = sub, 10 = use funct3/funct7.
- `ImmSrc` output 3: immediate format, combinational from `op`. I = 000, S = 001, B = 010, J = 011, U = 100, any other opcode = 000.
- `instr_done` output 1: one-cycle pulse on the final cycle of each instruction.

## Operation
Unlisted outputs are 0 in every state. `PCWrite` is defined as `PCUpdate | (Branch & taken)`.
- `S_RESET`: all outputs 0. Stays for `RESET_STALL` cycles, then goes to `S_FETCH`.
- `S_FETCH`:
  - Drives AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCUpdate are driven equal to `mem_ready`.
  - Stays in `S_FETCH` while `mem_ready` is 0; goes to `S_DECODE` when it is 1.
- `S_DECODE`: ALUSrcA=01, ALUSrcB=01, ALUOp=00, which leaves the OldPC+imm target in ALUOut. Next state by `op`:
  - 0000011 or 0100011 → `S_MEMADR`
  - 0110011 → `S_EXECR`
  - 0010011 → `S_EXECI`
  - 1100011 → `S_BRANCH`
  - 1101111 → `S_JAL`
  - 1100111 → `S_JALR`
  - 0110111 → `S_LUI`
  - 0010111 → `S_ALUWB`
  - any other opcode → the illegal path (see Configuration).
- `S_MEMADR`: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to `S_MEMWRITE` if `op[5]` is 1, otherwise to `S_MEMREAD`.
- `S_MEMREAD`: AdrSrc=1, ResultSrc=00. Waits for `mem_ready`, then goes to `S_MEMWB`.
- `S_MEMWB`: ResultSrc=01, RegWrite=1, then `S_FETCH`.
- `S_MEMWRITE`: AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite is held high until `mem_ready` is seen, then `S_FETCH`.
- `S_EXECR`: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then `S_ALUWB`.
- `S_EXECI`: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then `S_ALUWB`.
- `S_LUI`: ALUSrcA=11, ALUSrcB=01, ALUOp=00, then `S_ALUWB`.
- `S_ALUWB`: ResultSrc=00, RegWrite=1, then `S_FETCH`.
- `S_BRANCH`: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, then `S_FETCH`. `taken` by funct3:
  - 000: `zero`
  - 001: `!zero`
  - 100: `lt`
  - 101: `!lt`
  - 110: `ltu`
  - 111: `!ltu`
  - 010 and 011: 0.
- `S_JAL`: ResultSrc=00, PCUpdate=1, then `S_LINK`.
- `S_JALR`: ALUSrcA=10, ALUSrcB=01, ALUOp=00, ResultSrc=10, PCUpdate=1, then `S_LINK`.
- `S_LINK`: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=10, RegWrite=1, then `S_FETCH`.
- `instr_done` is 1 in the final state of each instruction: `S_MEMWB`, `S_ALUWB`, `S_BRANCH`, `S_LINK`, and `S_MEMWRITE` when `mem_ready` is 1.

## Timing
- State register updates on the rising edge of `clk`. All outputs are combinational from state, `op`, `funct3`, the ALU flags and `mem_ready`.
- Asserting `reset` at any time forces `S_RESET` immediately, so every output reads 0 within the same cycle. This applies even mid-instruction and mid-MemWrite.
- Cycles per instruction with `mem_ready` tied to 1: lw 5, sw 4, R 4, I 4, lui 4, auipc 3, branch 3, jal 4, jalr 4.
- Each cycle `mem_ready` is 0 in `S_FETCH`, `S_MEMREAD` or `S_MEMWRITE` adds exactly one cycle, with outputs unchanged.
- `op` and `funct3` are sampled only in `S_DECODE`, `S_MEMADR` and `S_BRANCH`. IR is stable in those states.

## Configuration
- `MAIN_FSM_ILLEGAL_TRAP_EN` defined:
  - An unknown opcode in `S_DECODE` goes to `S_ERROR`.
  - `S_ERROR` drives all outputs 0, asserts an added output `illegal` = 1, and is left only by reset.
- `MAIN_FSM_ILLEGAL_TRAP_EN` undefined:
  - An unknown opcode goes from `S_DECODE` straight back to `S_FETCH` and pulses `instr_done`, so it executes as a 2-cycle NOP.
  - The `illegal` port is absent.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - the state enum;
  - opcode constants;
  - the encodings for ResultSrc, ALUSrcA, ALUSrcB, ALUOp and ImmSrc.
- One sub-module, `branch_cond`: combinational map from `funct3` and `zero`/`lt`/`ltu` to `taken`.

## Test plan
- Reset released with `RESET_STALL`=1 and `mem_ready`=1 → one cycle of all-zero outputs, then `S_FETCH` with IRWrite=1 and PCWrite=1.
- lw (op 0000011), `mem_ready`=1 throughout → states F, D, MEMADR, MEMREAD, MEMWB; RegWrite=1 with ResultSrc=01 in cycle 5; `instr_done` in cycle 5.
- sw with `mem_ready` low for 3 cycles in `S_MEMWRITE` → MemWrite=1 for 4 consecutive cycles and `instr_done` only in the last of them; 7 cycles total.
- bne (funct3 001) in `S_BRANCH`: with `zero`=0 → PCWrite=1; with `zero`=1 → PCWrite=0; 3 cycles each.
- jalr → `S_JALR` with PCWrite=1 and ResultSrc=10, then `S_LINK` with RegWrite=1 and ALUSrcA=01, ALUSrcB=10.
- Opcode 1111111 → with the macro: `S_ERROR` with `illegal`=1, persisting until `reset`=0. Without the macro: back in `S_FETCH` on cycle 3.
